// File: rtl/figo_serializer_if.sv
// Load/serial bundle for figo_serializer: the word-load handshake in, the
// serial stream and frame status out.
interface figo_serializer_if #(
   parameter int WIDTH = 4
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   // Producer of words and consumer of the serial stream
   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  busy,
      input  done
   );

   // The serializer itself
   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output sout,
      output sout_valid,
      output busy,
      output done
   );
endinterface

// File: rtl/figo_serializer.sv
// Parallel-to-serial transmitter feeding the FIGO sequence FSM, MSB first,
// BIT_CYCLES clocks per bit. Define FIGO_PARITY_EN to append an even-parity bit.
module figo_serializer #(
   parameter int WIDTH      = 4,
   parameter int BIT_CYCLES = 1
) (
   input logic             clk,
   input logic             reset,
   figo_serializer_if.slave bus
);

   localparam int             BCW       = $clog2(WIDTH + 1);
   localparam logic [7:0]     HOLD_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
`ifdef FIGO_PARITY_EN
      S_PARITY = 2'd2,
`endif
      S_DONE   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [7:0]       hold_q, hold_d;
   logic [BCW-1:0]   bit_q, bit_d;
`ifdef FIGO_PARITY_EN
   logic             par_q, par_d;

   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   logic load_ready_q, load_ready_d;
   logic sout_q, sout_d;
   logic sout_valid_q, sout_valid_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   // Next-state logic: capture, per-bit hold counting, shifting and frame sequencing
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      hold_d  = hold_q;
      bit_d   = bit_q;
`ifdef FIGO_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.load_valid) begin
               state_d = S_SHIFT;
               shreg_d = bus.load_data;
               hold_d  = 8'd0;
               bit_d   = '0;
`ifdef FIGO_PARITY_EN
               par_d   = even_parity(bus.load_data);
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (hold_q == HOLD_LAST) begin
               hold_d  = 8'd0;
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               bit_d   = bit_q + BCW'(1);
               if (bit_q == BIT_LAST) begin
`ifdef FIGO_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_SHIFT;
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
`ifdef FIGO_PARITY_EN
         S_PARITY: begin
            if (hold_q == HOLD_LAST) begin
               hold_d  = 8'd0;
               state_d = S_DONE;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      load_ready_d = 1'b0;
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      case (state_d)
         S_IDLE: begin
            load_ready_d = 1'b1;
         end
         S_SHIFT: begin
            sout_d       = shreg_d[WIDTH-1];
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
         end
`ifdef FIGO_PARITY_EN
         S_PARITY: begin
            sout_d       = par_d;
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
         end
`endif
         S_DONE: begin
            load_ready_d = 1'b1;
            done_d       = 1'b1;
         end
         default: begin
            load_ready_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         shreg_q      <= '0;
         hold_q       <= 8'd0;
         bit_q        <= '0;
`ifdef FIGO_PARITY_EN
         par_q        <= 1'b0;
`endif
         load_ready_q <= 1'b1;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         hold_q       <= hold_d;
         bit_q        <= bit_d;
`ifdef FIGO_PARITY_EN
         par_q        <= par_d;
`endif
         load_ready_q <= load_ready_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.load_ready = load_ready_q;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule
